bubbledrive8_flash_arbiter: RTL and testbench
=============================================

// Module: bubbledrive8_flash_arbiter
// PURPOSE
//  Shares the single W25Q32 SPI flash pin set (nROMCS/ROMCLK/ROMIO0..3) between
//  two requesters: the emulator core (bubble image reads) and the USB core
//  (image upload, erase and program). Fixed priority to the emulator.
//  A granted transaction is never pre-empted. A chip-select guard gap is enforced
//  between owners. Sits in BubbleDrive8_top between the requesters and the flash pins.
// PARAMETERS
//  GUARD_CYCLES  3      MCLK cycles nROMCS is held high after release (>=50ns tSHSL)
//  MAX_WAIT      4800   emulator wait cycles (100us) before the EMUSTARVE flag sets
// PORTS
//  MCLK         in   1  48MHz system clock
//  nRESET       in   1  asynchronous active-low reset
//  nEMUREQ      in   1  emulator requests the flash (low = request)
//  nEMUGNT      out  1  emulator owns the flash (low = granted)
//  EMU_nCS      in   1  emulator chip select
//  EMU_CLK      in   1  emulator SPI clock
//  EMU_IO0      in   1  emulator MOSI
//  nUSBREQ      in   1  USB core requests the flash
//  nUSBGNT      out  1  USB core owns the flash
//  USB_nCS      in   1  USB chip select
//  USB_CLK      in   1  USB SPI clock
//  USB_IO0      in   1  USB MOSI
//  nROMCS       out  1  flash chip select
//  ROMCLK       out  1  flash clock
//  ROMIO0_O     out  1  flash IO0 drive value
//  ROMIO0_OE    out  1  flash IO0 output enable (1 = drive)
//  EMUSTARVE    out  1  sticky: emulator waited more than MAX_WAIT; cleared only by reset
// BEHAVIOUR
//  - Reset (async, nRESET=0): state=IDLE, nEMUGNT=1, nUSBGNT=1, nROMCS=1,
//    ROMCLK=0, ROMIO0_O=0, ROMIO0_OE=0, EMUSTARVE=0, all counters cleared.
//  - FSM (registered): IDLE, GNT_EMU, GNT_USB, GUARD.
//  - IDLE: if nEMUREQ=0 -> GNT_EMU; else if nUSBREQ=0 -> GNT_USB.
//    If both request in the same cycle, the emulator wins.
//    Grant output goes low on the clock edge after the request is sampled (1-cycle latency).
//  - GNT_x: the owner's nCS/CLK/IO0 pass combinationally to nROMCS/ROMCLK/ROMIO0_O.
//    ROMIO0_OE=1. The other requester's pins are ignored.
//  - Release: leave GNT_x only when nxREQ=1 AND x_nCS=1 in the same cycle.
//    If the request drops while x_nCS=0, keep the grant until nCS rises
//    (a transfer is never cut).
//  - The grant deasserts on the edge that enters GUARD.
//  - GUARD: nROMCS=1, ROMCLK=0, ROMIO0_OE=0 for exactly GUARD_CYCLES cycles, then IDLE.
//    Requests arriving during GUARD are held off. At IDLE, normal priority applies,
//    so the emulator wins even if the USB core requested first.
//  - Outside GNT_x, the flash pins carry their reset values.
//    ROMIO1..3 go directly to both requesters and are not arbitrated.
//  - Wait counter: 13-bit. Counts while nEMUREQ=0 and the FSM is not in GNT_EMU.
//    Clears when GNT_EMU is entered or nEMUREQ=1. Saturates at MAX_WAIT.
//    EMUSTARVE sets the cycle the count reaches MAX_WAIT.
//  - Requester rule: the grant is the only permission to drive. The USB core must
//    keep erase/program busy-polling in one or more short grants, not hold the bus for
//    the whole erase.
//  - Reset mid-transaction: outputs go to reset values immediately (async).
//    No transaction is resumed.
// TESTING
//  1. Reset with both nREQ=0 -> nROMCS=1, grants=1, OE=0.
//     Release reset -> nEMUGNT=0 one edge later; nUSBGNT stays 1.
//  2. nUSBREQ=0 alone -> nUSBGNT=0 next edge. USB_CLK toggling -> ROMCLK follows same cycle.
//  3. USB granted, nEMUREQ=0 mid-transfer (USB_nCS=0) -> no pre-emption.
//     USB drops REQ and nCS -> GUARD: nROMCS=1 for exactly 3 cycles, then nEMUGNT=0.
//  4. EMU drops nEMUREQ while EMU_nCS=0 for 10 cycles -> nEMUGNT stays 0
//     until EMU_nCS=1, then GUARD.
//  5. USB holds a 5000-cycle grant while EMU requests -> EMUSTARVE=1 after 4800 wait
//     cycles; stays 1 after EMU is served; 0 only after nRESET pulse.
//  6. Both requests in the same IDLE cycle -> EMU granted. After EMU release + guard,
//     USB granted.

Source files
------------

// File: rtl/bubbledrive8_flash_arbiter.sv
// Two-master arbiter for the shared SPI flash pins: emulator has fixed priority,
// grants are never pre-empted, and a chip-select guard gap separates owners.
module bubbledrive8_flash_arbiter #(
  parameter int GUARD_CYCLES = 3,
  parameter int MAX_WAIT     = 4800
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic nEMUREQ,
  output logic nEMUGNT,
  input  logic EMU_nCS,
  input  logic EMU_CLK,
  input  logic EMU_IO0,
  input  logic nUSBREQ,
  output logic nUSBGNT,
  input  logic USB_nCS,
  input  logic USB_CLK,
  input  logic USB_IO0,
  output logic nROMCS,
  output logic ROMCLK,
  output logic ROMIO0_O,
  output logic ROMIO0_OE,
  output logic EMUSTARVE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_EMU = 2'd1,
    GNT_USB = 2'd2,
    GUARD   = 2'd3
  } state_t;

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [12:0]   WAIT_MAX   = 13'(MAX_WAIT);

  state_t        state_q, state_d;
  state_t        pick;
  logic [GW-1:0] guard_q, guard_d;
  logic [12:0]   wait_q, wait_d;
  logic          starve_q, starve_d;
  logic          emu_gnt_q, emu_gnt_d;
  logic          usb_gnt_q, usb_gnt_d;

  // Priority decision used both from IDLE and on the last guard cycle.
  always_comb begin
    pick = IDLE;
    if (!nEMUREQ) begin
      pick = GNT_EMU;
    end else if (!nUSBREQ) begin
      pick = GNT_USB;
    end
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      IDLE: begin
        state_d = pick;
      end
      GNT_EMU: begin
        if (nEMUREQ && EMU_nCS) begin
          state_d = GUARD;
          guard_d = GUARD_LAST;
        end
      end
      GNT_USB: begin
        if (nUSBREQ && USB_nCS) begin
          state_d = GUARD;
          guard_d = GUARD_LAST;
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = pick;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    emu_gnt_d = (state_d == GNT_EMU);
    usb_gnt_d = (state_d == GNT_USB);
  end

  // Entering GNT_EMU clears the count on the same edge, so key off the next state.
  always_comb begin
    wait_d = '0;
    if (!nEMUREQ && (state_d != GNT_EMU)) begin
      wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : (wait_q + 13'd1);
    end
    starve_d = starve_q | (wait_d == WAIT_MAX);
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      guard_q   <= '0;
      wait_q    <= '0;
      starve_q  <= 1'b0;
      emu_gnt_q <= 1'b0;
      usb_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      emu_gnt_q <= emu_gnt_d;
      usb_gnt_q <= usb_gnt_d;
    end
  end

  // Owner pins pass through combinationally; otherwise the bus sits at idle levels.
  always_comb begin
    nROMCS    = 1'b1;
    ROMCLK    = 1'b0;
    ROMIO0_O  = 1'b0;
    ROMIO0_OE = 1'b0;
    if (emu_gnt_q) begin
      nROMCS    = EMU_nCS;
      ROMCLK    = EMU_CLK;
      ROMIO0_O  = EMU_IO0;
      ROMIO0_OE = 1'b1;
    end else if (usb_gnt_q) begin
      nROMCS    = USB_nCS;
      ROMCLK    = USB_CLK;
      ROMIO0_O  = USB_IO0;
      ROMIO0_OE = 1'b1;
    end
  end

  assign nEMUGNT   = ~emu_gnt_q;
  assign nUSBGNT   = ~usb_gnt_q;
  assign EMUSTARVE = starve_q;

endmodule

// File: tb/tb_bubbledrive8_flash_arbiter.sv
// Bench for the flash arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against an owner/guard/wait reference model.
module tb_bubbledrive8_flash_arbiter;

  localparam int GUARD = 3;
  localparam int MAXW  = 4800;

  logic MCLK = 1'b0;
  logic nRESET = 1'b0;
  logic nEMUREQ = 1'b1, EMU_nCS = 1'b1, EMU_CLK = 1'b0, EMU_IO0 = 1'b0;
  logic nUSBREQ = 1'b1, USB_nCS = 1'b1, USB_CLK = 1'b0, USB_IO0 = 1'b0;
  logic nEMUGNT, nUSBGNT, nROMCS, ROMCLK, ROMIO0_O, ROMIO0_OE, EMUSTARVE;

  always #5 MCLK = ~MCLK;

  bubbledrive8_flash_arbiter #(.GUARD_CYCLES(GUARD), .MAX_WAIT(MAXW)) dut (
    .MCLK(MCLK), .nRESET(nRESET),
    .nEMUREQ(nEMUREQ), .nEMUGNT(nEMUGNT), .EMU_nCS(EMU_nCS), .EMU_CLK(EMU_CLK), .EMU_IO0(EMU_IO0),
    .nUSBREQ(nUSBREQ), .nUSBGNT(nUSBGNT), .USB_nCS(USB_nCS), .USB_CLK(USB_CLK), .USB_IO0(USB_IO0),
    .nROMCS(nROMCS), .ROMCLK(ROMCLK), .ROMIO0_O(ROMIO0_O), .ROMIO0_OE(ROMIO0_OE),
    .EMUSTARVE(EMUSTARVE)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: who owns the bus, how many guard cycles remain, how long
  // the emulator has been waiting.
  int m_owner;   // 0 none, 1 emulator, 2 usb
  int m_guard;
  int m_wait;
  bit m_starve;

  always @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      m_owner = 0; m_guard = 0; m_wait = 0; m_starve = 0;
    end else begin
      if (m_owner == 1) begin
        if (nEMUREQ && EMU_nCS) begin m_owner = 0; m_guard = GUARD; end
      end else if (m_owner == 2) begin
        if (nUSBREQ && USB_nCS) begin m_owner = 0; m_guard = GUARD; end
      end else begin
        if (m_guard > 0) m_guard--;
        if (m_guard == 0) begin
          if (!nEMUREQ) m_owner = 1;
          else if (!nUSBREQ) m_owner = 2;
        end
      end
      if (!nEMUREQ && m_owner != 1) m_wait = (m_wait >= MAXW) ? MAXW : m_wait + 1;
      else m_wait = 0;
      if (m_wait == MAXW) m_starve = 1;
    end
  end

  function automatic logic [7:0] model_vec();
    logic ncs, clk, io, oe;
    ncs = 1'b1; clk = 1'b0; io = 1'b0; oe = 1'b0;
    if (m_owner == 1) begin ncs = EMU_nCS; clk = EMU_CLK; io = EMU_IO0; oe = 1'b1; end
    if (m_owner == 2) begin ncs = USB_nCS; clk = USB_CLK; io = USB_IO0; oe = 1'b1; end
    return {1'b0, (m_owner != 1), (m_owner != 2), ncs, clk, io, oe, m_starve};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {1'b0, nEMUGNT, nUSBGNT, nROMCS, ROMCLK, ROMIO0_O, ROMIO0_OE, EMUSTARVE};
  endfunction

  always @(posedge MCLK) begin
    #1;
    chk("cycle_vs_model", dut_vec(), model_vec());
  end

  task automatic pulse_reset();
    @(negedge MCLK); nRESET = 1'b0;
    @(negedge MCLK); nRESET = 1'b1;
  endtask

  initial begin
    // 1: reset with both requesting
    nEMUREQ = 1'b0; nUSBREQ = 1'b0;
    @(negedge MCLK);
    @(negedge MCLK);
    chk("reset_state", {4'b0, nEMUGNT, nUSBGNT, nROMCS, ROMIO0_OE}, 8'b0000_1110);
    chk("reset_starve", {7'b0, EMUSTARVE}, 8'd0);
    nRESET = 1'b1;
    @(negedge MCLK);
    chk("first_grant_emu", {6'b0, nEMUGNT, nUSBGNT}, 8'b0000_0001);
    nEMUREQ = 1'b1;
    repeat (6) @(negedge MCLK);

    // 2: USB alone, clock passes through same cycle, then async reset mid-transfer
    nUSBREQ = 1'b1;
    pulse_reset();
    nUSBREQ = 1'b0;
    @(negedge MCLK);
    chk("usb_grant", {6'b0, nEMUGNT, nUSBGNT}, 8'b0000_0010);
    USB_nCS = 1'b0; USB_CLK = 1'b1; USB_IO0 = 1'b1;
    #1;
    chk("usb_passthru", {4'b0, nROMCS, ROMCLK, ROMIO0_O, ROMIO0_OE}, 8'b0000_0111);
    USB_CLK = 1'b0;
    #1;
    chk("usb_clk_follow", {7'b0, ROMCLK}, 8'd0);
    USB_CLK = 1'b1;
    #1;
    nRESET = 1'b0;
    #1;
    chk("async_reset", {4'b0, nUSBGNT, nROMCS, ROMCLK, ROMIO0_OE}, 8'b0000_1100);
    @(negedge MCLK); nRESET = 1'b1; USB_CLK = 1'b0;

    // 3: USB owns mid-transfer, emulator requests, no pre-emption, then guard
    @(negedge MCLK);
    chk("usb_regrant", {7'b0, nUSBGNT}, 8'd0);
    nEMUREQ = 1'b0;
    repeat (5) @(negedge MCLK);
    chk("no_preempt", {6'b0, nEMUGNT, nUSBGNT}, 8'b0000_0010);
    nUSBREQ = 1'b1; USB_nCS = 1'b1;
    for (int i = 0; i < GUARD; i++) begin
      @(negedge MCLK);
      chk("guard_gap", {5'b0, nEMUGNT, nUSBGNT, nROMCS}, 8'b0000_0111);
    end
    @(negedge MCLK);
    chk("emu_after_guard", {6'b0, nEMUGNT, nUSBGNT}, 8'b0000_0001);

    // 4: emulator drops request mid-transfer, grant holds until nCS rises
    EMU_nCS = 1'b0;
    @(negedge MCLK);
    nEMUREQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      chk("emu_hold", {7'b0, nEMUGNT}, 8'd0);
    end
    EMU_nCS = 1'b1;
    @(negedge MCLK);
    chk("emu_release", {6'b0, nEMUGNT, nROMCS}, 8'b0000_0011);
    repeat (5) @(negedge MCLK);

    // 5: starvation flag during a long USB grant
    nUSBREQ = 1'b0; USB_nCS = 1'b0;
    pulse_reset();
    @(negedge MCLK);
    chk("usb_long_grant", {7'b0, nUSBGNT}, 8'd0);
    nEMUREQ = 1'b0;
    repeat (MAXW - 1) @(negedge MCLK);
    chk("starve_before", {7'b0, EMUSTARVE}, 8'd0);
    @(negedge MCLK);
    chk("starve_set", {7'b0, EMUSTARVE}, 8'd1);
    repeat (150) @(negedge MCLK);
    nUSBREQ = 1'b1; USB_nCS = 1'b1;
    repeat (GUARD + 2) @(negedge MCLK);
    chk("starve_sticky", {6'b0, nEMUGNT, EMUSTARVE}, 8'b0000_0001);
    nEMUREQ = 1'b1;
    @(negedge MCLK); nRESET = 1'b0;
    #1;
    chk("starve_cleared", {7'b0, EMUSTARVE}, 8'd0);
    @(negedge MCLK); nRESET = 1'b1;

    // 6: simultaneous requests, emulator first then USB after guard
    @(negedge MCLK);
    nEMUREQ = 1'b0; nUSBREQ = 1'b0;
    @(negedge MCLK);
    chk("tie_emu_wins", {6'b0, nEMUGNT, nUSBGNT}, 8'b0000_0001);
    nEMUREQ = 1'b1;
    repeat (GUARD + 1) @(negedge MCLK);
    chk("usb_after_emu", {6'b0, nEMUGNT, nUSBGNT}, 8'b0000_0010);
    nUSBREQ = 1'b1;
    repeat (6) @(negedge MCLK);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge MCLK);
      if ($urandom_range(7) == 0) nEMUREQ = ~nEMUREQ;
      if ($urandom_range(7) == 0) nUSBREQ = ~nUSBREQ;
      if ($urandom_range(5) == 0) EMU_nCS = ~EMU_nCS;
      if ($urandom_range(5) == 0) USB_nCS = ~USB_nCS;
      EMU_CLK = 1'($urandom); EMU_IO0 = 1'($urandom);
      USB_CLK = 1'($urandom); USB_IO0 = 1'($urandom);
      if (!nRESET) nRESET = 1'b1;
      else if ($urandom_range(399) == 0) begin
        #2 nRESET = 1'b0;
      end
    end
    nRESET = 1'b1;
    repeat (3) @(negedge MCLK);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
